// File: rtl/seg_pkg.sv
// Shared types and glyph table for the 7-segment scan display path.
package seg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {ST_GAP, ST_SHOW} scan_state_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_GLYPH [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Shared combinational BCD to active-low 7-segment decoder; non-BCD codes blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) seg_c = SEG_GLYPH[i];
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed common-anode display driver with frame-atomic double buffering,
// inter-digit dead time and optional leading-zero blanking.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_GAP  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic                    pending,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(BLANK_GAP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  // With no dead time every slot starts directly in SHOW
  localparam scan_state_t SLOT_START = (BLANK_GAP == 0) ? ST_SHOW : ST_GAP;

  scan_state_t                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0]       active_q, active_d;
  bcd_t [NUM_DIGITS-1:0]       shadow_q, shadow_d;
  logic                        pending_d;
  logic [6:0]                  seg_d;
  logic [NUM_DIGITS-1:0]       an_d;
  logic                        frame_done_d;

  logic                        cnt_last, idx_last, boundary;
  logic [NUM_DIGITS-1:0]       lz;
  logic                        zero_run;
  logic [3:0]                  bcd_sel;
  logic [6:0]                  dec_seg;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign idx_last = (idx_q == IDX_LAST);
  assign boundary = cnt_last && idx_last;
  assign bcd_sel  = active_q[idx_q];

  bcd_to_seg u_dec (
    .bcd   (bcd_sel),
    .seg_c (dec_seg)
  );

  // lz[k]: digit k and every more-significant digit are zero (digit 0 never blanked)
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run = zero_run & (active_q[k] == 4'd0);
      lz[k]    = zero_run && (k != 0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT_START;
      cnt_q      <= '0;
      idx_q      <= '0;
      active_q   <= '0;
      shadow_q   <= '0;
      pending    <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      pending    <= pending_d;
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending;
    seg_d        = SEG_BLANK;
    an_d         = '1;
    frame_done_d = 1'b0;

    if (cnt_last) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end

    case (state_q)
      ST_GAP: begin
        if (cnt_d == GAP_END) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        an_d[idx_q] = 1'b0;
        seg_d       = (blank_lz && lz[idx_q]) ? SEG_BLANK : dec_seg;
        if (cnt_last) state_d = SLOT_START;
      end
      default: state_d = SLOT_START;
    endcase

    // Active only changes on the frame boundary; a same-cycle load bypasses the shadow
    if (boundary) begin
      frame_done_d = 1'b1;
      if (load) begin
        active_d  = digits_in;
        pending_d = 1'b0;
      end else if (pending) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with NUM_DIGITS=4, SCAN_DIV=8, BLANK_GAP=2.
module tb_seg_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic        pending;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_controller #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (8),
    .BLANK_GAP  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .pending    (pending),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle load from a negedge; returns one negedge later
  task automatic drive_load(input logic [15:0] v);
    load      = 1'b1;
    digits_in = v;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Called on the frame_done cycle (cnt=0, idx=0); digit k is visible at offset 8k+4
  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e [4];
    logic [3:0] ea;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int k = 0; k < 4; k++) begin
      step((k == 0) ? 4 : 8);
      ea    = 4'hF;
      ea[k] = 1'b0;
      chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'(ea));
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(e[k]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;
    blank_lz  = 1'b0;

    // Reset state
    step(3);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    // First digit appears three cycles after release
    step(2);
    chk("gap_an", 32'(an), 32'hF);
    step(1);
    chk("first_an", 32'(an), 32'hE);
    chk("first_seg", 32'(seg), 32'h40);
    step(28);
    chk("fd_before", 32'(frame_done), 32'h0);
    step(1);
    chk("fd_first", 32'(frame_done), 32'h1);
    step(1);
    chk("fd_pulse_end", 32'(frame_done), 32'h0);
    step(31);
    chk("fd_period", 32'(frame_done), 32'h1);

    // Mid-frame load of 1234
    step(10);
    drive_load(16'h1234);
    chk("ld_pending", 32'(pending), 32'h1);
    step(20);
    chk("ld_pending_hold", 32'(pending), 32'h1);
    step(1);
    chk("ld_fd", 32'(frame_done), 32'h1);
    chk("ld_pending_clr", 32'(pending), 32'h0);
    check_digits("d1234", 7'h19, 7'h30, 7'h24, 7'h79);

    // Two loads in one frame: last wins
    drive_load(16'h1111);
    step(1);
    drive_load(16'h2222);
    chk("dbl_pending", 32'(pending), 32'h1);
    step(1);
    chk("dbl_fd", 32'(frame_done), 32'h1);
    check_digits("d2222", 7'h24, 7'h24, 7'h24, 7'h24);

    // Leading-zero blanking
    drive_load(16'h0050);
    blank_lz = 1'b1;
    step(3);
    chk("lz_fd", 32'(frame_done), 32'h1);
    check_digits("lz_on", 7'h40, 7'h12, 7'h7F, 7'h7F);
    blank_lz = 1'b0;
    step(4);
    check_digits("lz_off", 7'h40, 7'h12, 7'h40, 7'h40);

    // Non-BCD code blanks with anode still driven
    drive_load(16'hA009);
    step(3);
    check_digits("dA009", 7'h18, 7'h40, 7'h40, 7'h7F);

    // Load in the frame-boundary cycle bypasses the shadow
    step(3);
    load      = 1'b1;
    digits_in = 16'h5678;
    step(1);
    load      = 1'b0;
    chk("bnd_fd", 32'(frame_done), 32'h1);
    chk("bnd_pending", 32'(pending), 32'h0);
    check_digits("d5678", 7'h00, 7'h78, 7'h02, 7'h12);
    chk("bnd_pending_end", 32'(pending), 32'h0);

    // Async reset during SHOW with a pending load
    drive_load(16'h9999);
    chk("ar_pending_pre", 32'(pending), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_seg", 32'(seg), 32'h7F);
    chk("ar_an", 32'(an), 32'hF);
    chk("ar_pending", 32'(pending), 32'h0);
    step(2);
    rst_n = 1'b1;
    check_digits("ar_f0", 7'h40, 7'h40, 7'h40, 7'h40);
    step(4);
    chk("ar_fd", 32'(frame_done), 32'h1);
    check_digits("ar_f1", 7'h40, 7'h40, 7'h40, 7'h40);
    chk("ar_pending_end", 32'(pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
